// File: rtl/crc8_link_pkg.sv
// Shared definitions for the serial CRC-8 link (generator and checker).
// Holds the polynomial, the FSM state type and the one-bit LFSR step.
package crc8_link_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        DONE
    } state_t;

    // One division step of the frame by x^8+x^2+x+1, MSB first.
    // The incoming bit enters at bit 0; the old MSB selects the polynomial.
    function automatic logic [7:0] crc8_step(input logic [7:0] c,
                                             input logic       d);
        return {c[6:0], d} ^ (c[7] ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker: deserialises PAYLOAD_BITS + 8 check bits,
// reports pass/fail per frame and keeps a saturating bad-frame count.
// Ports: clk (state on falling edge), reset (sync, active-low), bit_in,
//   bit_valid, sof -> payload, frame_done, crc_ok, remainder, frame_abort,
//   err_count.
module crc8_frame_checker
    import crc8_link_pkg::*;
#(
    parameter int PAYLOAD_BITS = 16,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    input  logic                    sof,
    output logic [PAYLOAD_BITS-1:0] payload,
    output logic                    frame_done,
    output logic                    crc_ok,
    output logic [7:0]              remainder,
    output logic                    frame_abort,
    output logic [ERR_CNT_W-1:0]    err_count
);

    localparam int             CNT_W    = 7;
    localparam logic [CNT_W-1:0] LAST_PL  = CNT_W'(PAYLOAD_BITS);
    localparam logic [CNT_W-1:0] LAST_CHK = CNT_W'(8);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_lfsr;
    logic [7:0]              w_lfsr_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic [PAYLOAD_BITS-1:0] w_shift_nxt;

    logic [PAYLOAD_BITS-1:0] r_payload;
    logic [PAYLOAD_BITS-1:0] w_payload_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    r_ok;
    logic                    w_ok_nxt;
    logic [7:0]              r_rem;
    logic [7:0]              w_rem_nxt;
    logic                    r_abort;
    logic                    w_abort_nxt;
    logic [ERR_CNT_W-1:0]    r_err;
    logic [ERR_CNT_W-1:0]    w_err_nxt;

    logic                    w_start;
    logic [7:0]              w_lfsr_step;
    logic [7:0]              w_lfsr_first;
    logic [PAYLOAD_BITS-1:0] w_shift_in;
    logic [CNT_W-1:0]        w_cnt_inc;
    state_t                  w_first_state;
    logic [CNT_W-1:0]        w_first_cnt;

    assign w_start      = bit_valid & sof;
    assign w_lfsr_step  = crc8_step(r_lfsr, bit_in);
    assign w_lfsr_first = crc8_step(CRC8_INIT, bit_in);
    assign w_shift_in   = (r_shift << 1) | PAYLOAD_BITS'(bit_in);
    assign w_cnt_inc    = r_cnt + 1'b1;

    // A one-bit payload is complete on the sof bit itself.
    assign w_first_state = (PAYLOAD_BITS == 1) ? CHECK : PAYLOAD;
    assign w_first_cnt   = (PAYLOAD_BITS == 1) ? '0 : CNT_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_lfsr_nxt    = r_lfsr;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_payload_nxt = r_payload;
        w_done_nxt    = 1'b0;
        w_ok_nxt      = r_ok;
        w_rem_nxt     = r_rem;
        w_abort_nxt   = 1'b0;
        w_err_nxt     = r_err;

        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = w_first_state;
                    w_lfsr_nxt  = w_lfsr_first;
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = w_first_cnt;
                end
            end
            PAYLOAD: begin
                if (w_start) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = w_first_state;
                    w_lfsr_nxt  = w_lfsr_first;
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = w_first_cnt;
                end else if (bit_valid) begin
                    w_lfsr_nxt  = w_lfsr_step;
                    w_shift_nxt = w_shift_in;
                    if (w_cnt_inc == LAST_PL) begin
                        w_state_nxt = CHECK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
            end
            CHECK: begin
                if (w_start) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = w_first_state;
                    w_lfsr_nxt  = w_lfsr_first;
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = w_first_cnt;
                end else if (bit_valid) begin
                    w_lfsr_nxt = w_lfsr_step;
                    if (w_cnt_inc == LAST_CHK) begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
            end
            DONE: begin
                w_done_nxt    = 1'b1;
                w_ok_nxt      = (r_lfsr == 8'h00);
                w_rem_nxt     = r_lfsr;
                w_payload_nxt = r_shift;
                if ((r_lfsr != 8'h00) && (r_err != '1)) begin
                    w_err_nxt = r_err + 1'b1;
                end
                w_state_nxt = IDLE;
                w_lfsr_nxt  = CRC8_INIT;
                w_cnt_nxt   = '0;
                // Back-to-back frame: the next sof bit is taken right here.
                if (w_start) begin
                    w_state_nxt = w_first_state;
                    w_lfsr_nxt  = w_lfsr_first;
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = w_first_cnt;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_lfsr    <= CRC8_INIT;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_payload <= '0;
            r_done    <= 1'b0;
            r_ok      <= 1'b0;
            r_rem     <= 8'h00;
            r_abort   <= 1'b0;
            r_err     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_payload <= w_payload_nxt;
            r_done    <= w_done_nxt;
            r_ok      <= w_ok_nxt;
            r_rem     <= w_rem_nxt;
            r_abort   <= w_abort_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign payload     = r_payload;
    assign frame_done  = r_done;
    assign crc_ok      = r_ok;
    assign remainder   = r_rem;
    assign frame_abort = r_abort;
    assign err_count   = r_err;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Bench for crc8_frame_checker: random and directed frames checked against
// a polynomial long-division reference and an expected-frame queue.
module tb_crc8_frame_checker;

    localparam int PB = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          sof = 1'b0;

    logic [PB-1:0] payload, payload2;
    logic          frame_done, frame_done2;
    logic          crc_ok, crc_ok2;
    logic [7:0]    remainder, remainder2;
    logic          frame_abort, frame_abort2;
    logic [7:0]    err_count;
    logic [1:0]    err_count2;

    crc8_frame_checker #(.PAYLOAD_BITS(PB), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(rst_n), .bit_in(bit_in),
        .bit_valid(bit_valid), .sof(sof),
        .payload(payload), .frame_done(frame_done), .crc_ok(crc_ok),
        .remainder(remainder), .frame_abort(frame_abort),
        .err_count(err_count)
    );

    crc8_frame_checker #(.PAYLOAD_BITS(PB), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset(rst_n), .bit_in(bit_in),
        .bit_valid(bit_valid), .sof(sof),
        .payload(payload2), .frame_done(frame_done2), .crc_ok(crc_ok2),
        .remainder(remainder2), .frame_abort(frame_abort2),
        .err_count(err_count2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(negedge clk) cyc++;

    typedef struct {
        logic [PB-1:0] pl;
        logic [7:0]    rem;
        logic          ok;
        int            at;
    } exp_t;

    exp_t          q[$];
    exp_t          e_m;
    logic [PB-1:0] m_pl = '0;
    logic [7:0]    m_rem = 8'h00;
    logic          m_ok = 1'b0;
    int            m_err8 = 0;
    int            m_err2 = 0;
    int            in_frame = 0;
    int            exp_aborts = 0;
    int            seen_aborts = 0;
    bit            started = 1'b0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of the whole frame modulo x^8+x^2+x+1 by long division.
    function automatic logic [7:0] ref_rem(input logic [23:0] f);
        logic [23:0] r;
        r = f;
        for (int k = 23; k >= 8; k--) begin
            if (r[k]) r = r ^ (24'h107 << (k - 8));
        end
        return r[7:0];
    endfunction

    function automatic logic [7:0] good_chk(input logic [PB-1:0] pl);
        return ref_rem({pl, 8'h00});
    endfunction

    always @(posedge clk) begin
        #1;
        if (started) begin
            if (frame_abort) seen_aborts++;
            chk("done_abort_excl", 64'(frame_done & frame_abort), 64'(0));
            chk("dut2_done_match", 64'(frame_done2), 64'(frame_done));
            chk("dut2_abort_match", 64'(frame_abort2), 64'(frame_abort));
            if (frame_done) begin
                chk("done_expected", 64'(q.size() > 0), 64'(1));
                if (q.size() > 0) begin
                    e_m = q.pop_front();
                    chk("done_latency", 64'(cyc), 64'(e_m.at));
                    m_pl  = e_m.pl;
                    m_rem = e_m.rem;
                    m_ok  = e_m.ok;
                    if (!e_m.ok) begin
                        if (m_err8 < 255) m_err8++;
                        if (m_err2 < 3) m_err2++;
                    end
                end
            end
            chk("payload", 64'(payload), 64'(m_pl));
            chk("crc_ok", 64'(crc_ok), 64'(m_ok));
            chk("remainder", 64'(remainder), 64'(m_rem));
            chk("err_count", 64'(err_count), 64'(m_err8));
            chk("err_count_w2", 64'(err_count2), 64'(m_err2));
            chk("dut2_payload", 64'(payload2), 64'(m_pl));
        end
    end

    task automatic drive(input logic v, input logic b, input logic s);
        @(posedge clk);
        bit_valid = v;
        bit_in    = b;
        sof       = s;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [23:0] f, input int nbits,
                             input int maxgap, input bit full);
        for (int i = 0; i < nbits; i++) begin
            repeat ($urandom_range(maxgap, 0))
                drive(1'b0, 1'($urandom), 1'($urandom));
            if (i == 0 && in_frame > 0) exp_aborts++;
            drive(1'b1, f[23-i], i == 0);
            in_frame = i + 1;
            if (full && i == 23) begin
                q.push_back('{f[23:8], ref_rem(f), ref_rem(f) == 8'h00,
                              cyc + 2});
                in_frame = 0;
            end
        end
    endtask

    task automatic send_frame(input logic [PB-1:0] pl, input logic [7:0] c,
                              input int maxgap);
        send_bits({pl, c}, 24, maxgap, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        sof       = 1'b0;
        @(posedge clk);
        rst_n    = 1'b1;
        chk("queue_empty_at_reset", 64'(q.size()), 64'(0));
        m_pl     = '0;
        m_rem    = 8'h00;
        m_ok     = 1'b0;
        m_err8   = 0;
        m_err2   = 0;
        in_frame = 0;
    endtask

    initial begin
        logic [PB-1:0] pl;
        logic [7:0]    c;
        repeat (3) @(posedge clk);
        rst_n   = 1'b1;
        started = 1'b1;
        idle(3);

        send_frame(16'h0001, 8'h07, 0);
        idle(4);
        send_frame(16'h0100, 8'h14, 0);
        send_frame(16'hFFFF, 8'h24, 0);
        idle(4);

        send_frame(16'hFFFF, 8'h24, 5);
        idle(4);

        send_bits({16'hA5C3, 8'h00}, 10, 0, 1'b0);
        send_frame(16'h0001, 8'h07, 0);
        idle(4);
        chk("abort_count_directed", 64'(seen_aborts), 64'(exp_aborts));

        send_bits({16'h1234, 8'h00}, 20, 0, 1'b0);
        do_reset();
        idle(2);
        send_frame(16'h0001, 8'h07, 0);
        send_frame(16'h0100, 8'h15, 0);
        idle(4);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            pl = 16'($urandom);
            send_frame(pl, good_chk(pl) ^ 8'($urandom_range(255, 1)), 1);
        end
        idle(4);

        for (int i = 0; i < 40; i++) begin
            pl = 16'($urandom);
            c  = good_chk(pl);
            if ($urandom_range(1, 0) == 1) c = 8'($urandom);
            if ($urandom_range(4, 0) == 0)
                send_bits({16'($urandom), 8'($urandom)},
                          $urandom_range(23, 1), 2, 1'b0);
            send_frame(pl, c, $urandom_range(3, 0));
            if ($urandom_range(2, 0) == 0) idle($urandom_range(3, 0));
        end

        idle(10);
        chk("pending_frames", 64'(q.size()), 64'(0));
        chk("abort_count", 64'(seen_aborts), 64'(exp_aborts));
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
